// File: rtl/wb_hyperram_pkg.sv
// ---------------------------------------------------------------------------
// wb_hyperram_pkg
// Shared definitions for the wb_hyperram master arbiter:
//   - arb_state_t      : arbiter FSM states (IDLE / GNT0 / GNT1 / FLUSH)
//   - ERR_DATA_DEFAULT : read data handed back when the watchdog ends a transfer
// ---------------------------------------------------------------------------
package wb_hyperram_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GNT0  = 2'd1,
      ST_GNT1  = 2'd2,
      ST_FLUSH = 2'd3
   } arb_state_t;

   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_rr_pick2.sv
// ---------------------------------------------------------------------------
// wb_rr_pick2
// Two-input round-robin picker.
//   i_req  [1:0] : request vector (bit n = master n)
//   i_last       : master that owned the bus most recently
//   o_gnt  [1:0] : one-hot pick, 00 when nobody requests
// ---------------------------------------------------------------------------
module wb_rr_pick2 (
   input  logic [1:0] i_req,
   input  logic       i_last,
   output logic [1:0] o_gnt
);

   // A lone requester wins outright; a tie goes to the master that was not last.
   always_comb begin
      o_gnt = 2'b00;
      case (i_req)
         2'b01:   o_gnt = 2'b01;
         2'b10:   o_gnt = 2'b10;
         2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
         default: o_gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/wb_hyperram_arbiter.sv
// ---------------------------------------------------------------------------
// wb_hyperram_arbiter
// Shares one wb_hyperram Wishbone slave between two classic Wishbone masters
// with round-robin arbitration, a bounded grant hold and a hung-transfer
// watchdog.
//   wb_clk_i / wb_rstn_i     : clock, synchronous active-low reset
//   m0_* / m1_*              : master ports (cyc, stb, we, sel, adr, dat in;
//                              ack, dat out)
//   s_*                      : slave port towards wb_hyperram
//   grant_o [1:0]            : one-hot current owner, 00 = none
//   timeout_o                : sticky watchdog flag, cleared only by reset
// The granted master is routed to the slave combinationally, so acks and
// read data come back with no added latency.
// ---------------------------------------------------------------------------
module wb_hyperram_arbiter #(
   parameter int unsigned MAX_HOLD = 4,
   parameter int unsigned TIMEOUT  = 1024,
   parameter logic [31:0] ERR_DATA = wb_hyperram_pkg::ERR_DATA_DEFAULT
) (
   input  logic        wb_clk_i,
   input  logic        wb_rstn_i,
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   input  logic        m0_we_i,
   input  logic [3:0]  m0_sel_i,
   input  logic [31:0] m0_adr_i,
   input  logic [31:0] m0_dat_i,
   output logic        m0_ack_o,
   output logic [31:0] m0_dat_o,
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_sel_i,
   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   output logic        m1_ack_o,
   output logic [31:0] m1_dat_o,
   output logic        s_cyc_o,
   output logic        s_stb_o,
   output logic        s_we_o,
   output logic [3:0]  s_sel_o,
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   input  logic        s_ack_i,
   input  logic [31:0] s_dat_i,
   output logic [1:0]  grant_o,
   output logic        timeout_o
);

   import wb_hyperram_pkg::*;

   localparam int unsigned   HW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam int unsigned   WW        = $clog2(TIMEOUT);
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
   localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
   localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT - 1);
   localparam logic [WW-1:0] WD_ONE    = WW'(1);

   arb_state_t    r_state;
   arb_state_t    w_next;
   arb_state_t    w_other;
   logic          r_last;
   logic [HW-1:0] r_hold;
   logic [WW-1:0] r_wdog;
   logic          r_quiet;
   logic          r_timeout;

   logic          w_req0;
   logic          w_req1;
   logic [1:0]    w_pick;
   logic          w_in_gnt;
   logic          w_own_cyc;
   logic          w_own_stb;
   logic          w_oth_req;
   logic          w_fire;

   assign w_req0 = m0_cyc_i & m0_stb_i;
   assign w_req1 = m1_cyc_i & m1_stb_i;

   wb_rr_pick2 u_pick (
      .i_req  ({w_req1, w_req0}),
      .i_last (r_last),
      .o_gnt  (w_pick)
   );

   // Owner-relative view of the bus used by the FSM and the watchdog.
   always_comb begin
      w_in_gnt  = 1'b0;
      w_own_cyc = 1'b0;
      w_own_stb = 1'b0;
      w_oth_req = 1'b0;
      w_other   = ST_IDLE;
      case (r_state)
         ST_GNT0: begin
            w_in_gnt  = 1'b1;
            w_own_cyc = m0_cyc_i;
            w_own_stb = m0_stb_i;
            w_oth_req = w_req1;
            w_other   = ST_GNT1;
         end
         ST_GNT1: begin
            w_in_gnt  = 1'b1;
            w_own_cyc = m1_cyc_i;
            w_own_stb = m1_stb_i;
            w_oth_req = w_req0;
            w_other   = ST_GNT0;
         end
         default: begin
            w_in_gnt  = 1'b0;
            w_own_cyc = 1'b0;
            w_own_stb = 1'b0;
            w_oth_req = 1'b0;
            w_other   = ST_IDLE;
         end
      endcase
      // A real ack in the expiry cycle beats the watchdog.
      w_fire = w_in_gnt & w_own_cyc & w_own_stb & ~s_ack_i & (r_wdog == WD_LAST);
   end

   // Bus routing: only the granted master ever reaches the slave.
   always_comb begin
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_we_o   = 1'b0;
      s_sel_o  = 4'h0;
      s_adr_o  = 32'h0000_0000;
      s_dat_o  = 32'h0000_0000;
      m0_ack_o = 1'b0;
      m0_dat_o = 32'h0000_0000;
      m1_ack_o = 1'b0;
      m1_dat_o = 32'h0000_0000;
      grant_o  = 2'b00;
      case (r_state)
         ST_GNT0: begin
            s_cyc_o  = m0_cyc_i & ~w_fire;
            s_stb_o  = m0_stb_i & ~w_fire;
            s_we_o   = m0_we_i;
            s_sel_o  = m0_sel_i;
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            m0_ack_o = s_ack_i | w_fire;
            m0_dat_o = w_fire ? ERR_DATA : s_dat_i;
            grant_o  = 2'b01;
         end
         ST_GNT1: begin
            s_cyc_o  = m1_cyc_i & ~w_fire;
            s_stb_o  = m1_stb_i & ~w_fire;
            s_we_o   = m1_we_i;
            s_sel_o  = m1_sel_i;
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            m1_ack_o = s_ack_i | w_fire;
            m1_dat_o = w_fire ? ERR_DATA : s_dat_i;
            grant_o  = 2'b10;
         end
         default: begin
            grant_o  = 2'b00;
         end
      endcase
   end

   // Next-state logic: arbitration, hold limit, abort and flush exit.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_pick[0]) begin
               w_next = ST_GNT0;
            end else if (w_pick[1]) begin
               w_next = ST_GNT1;
            end else begin
               w_next = ST_IDLE;
            end
         end
         ST_GNT0, ST_GNT1: begin
            if (s_ack_i) begin
               if (w_oth_req && (r_hold == HOLD_LAST)) begin
                  w_next = w_other;
               end else if (w_own_cyc) begin
                  w_next = r_state;
               end else if (w_oth_req) begin
                  w_next = w_other;
               end else begin
                  w_next = ST_IDLE;
               end
            end else if (w_fire) begin
               w_next = ST_FLUSH;
            end else if (!w_own_cyc) begin
               w_next = ST_IDLE;
            end else begin
               w_next = r_state;
            end
         end
         ST_FLUSH: begin
            // r_quiet marks one ack-free cycle already seen in FLUSH.
            if (!s_ack_i && r_quiet) begin
               w_next = ST_IDLE;
            end else begin
               w_next = ST_FLUSH;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // State, round-robin pointer, saturating counters and sticky flag.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rstn_i) begin
         r_state   <= ST_IDLE;
         r_last    <= 1'b1;
         r_hold    <= '0;
         r_wdog    <= '0;
         r_quiet   <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state <= w_next;

         if ((w_next == ST_GNT0) && (r_state != ST_GNT0)) begin
            r_last <= 1'b0;
         end else if ((w_next == ST_GNT1) && (r_state != ST_GNT1)) begin
            r_last <= 1'b1;
         end else begin
            r_last <= r_last;
         end

         if (w_next != r_state) begin
            r_hold <= '0;
         end else if (w_in_gnt && s_ack_i && (r_hold != HOLD_LAST)) begin
            r_hold <= r_hold + HOLD_ONE;
         end else begin
            r_hold <= r_hold;
         end

         if ((w_next != r_state) || s_ack_i) begin
            r_wdog <= '0;
         end else if (w_in_gnt && w_own_cyc && w_own_stb && (r_wdog != WD_LAST)) begin
            r_wdog <= r_wdog + WD_ONE;
         end else begin
            r_wdog <= r_wdog;
         end

         r_quiet <= (r_state == ST_FLUSH) && !s_ack_i;

         if (w_fire) begin
            r_timeout <= 1'b1;
         end else begin
            r_timeout <= r_timeout;
         end
      end
   end

   assign timeout_o = r_timeout;

endmodule

// File: tb/tb_wb_hyperram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_hyperram_arbiter
// Directed bench for wb_hyperram_arbiter (MAX_HOLD = 4, TIMEOUT = 16).
// Inputs change 1 time unit after the rising edge, outputs are checked on
// the falling edge. Expected read data is queued when a read is issued and
// popped when the owning master sees its ack.
// ---------------------------------------------------------------------------
module tb_wb_hyperram_arbiter;

   logic        clk = 1'b0;
   logic        wb_rstn_i;
   logic        m0_cyc_i, m0_stb_i, m0_we_i;
   logic [3:0]  m0_sel_i;
   logic [31:0] m0_adr_i, m0_dat_i;
   logic        m0_ack_o;
   logic [31:0] m0_dat_o;
   logic        m1_cyc_i, m1_stb_i, m1_we_i;
   logic [3:0]  m1_sel_i;
   logic [31:0] m1_adr_i, m1_dat_i;
   logic        m1_ack_o;
   logic [31:0] m1_dat_o;
   logic        s_cyc_o, s_stb_o, s_we_o;
   logic [3:0]  s_sel_o;
   logic [31:0] s_adr_o, s_dat_o;
   logic        s_ack_i;
   logic [31:0] s_dat_i;
   logic [1:0]  grant_o;
   logic        timeout_o;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   wb_hyperram_arbiter #(.MAX_HOLD(4), .TIMEOUT(16), .ERR_DATA(32'hDEAD_BEEF)) dut (
      .wb_clk_i(clk), .wb_rstn_i(wb_rstn_i),
      .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
      .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o),
      .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
      .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
      .grant_o(grant_o), .timeout_o(timeout_o)
   );

   task automatic check1(input string tag, input logic obs, input logic expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, expv);
      end
   endtask

   task automatic check2(input string tag, input logic [1:0] obs, input logic [1:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, expv);
      end
   endtask

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Ack must be seen; the returned data is compared with the queue head.
   task automatic expect_rd(input string tag, input logic ack, input logic [31:0] dat);
      logic [31:0] expv;
      check1({tag, "_ack"}, ack, 1'b1);
      n_checks++;
      assert (exp_q.size() != 0) else begin
         n_errors++;
         $error("FAIL %s_sb: observed empty queue expected pending read", tag);
      end
      if (exp_q.size() != 0) begin
         expv = exp_q.pop_front();
         check32({tag, "_dat"}, dat, expv);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic set_m0(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d);
      m0_cyc_i = c; m0_stb_i = c; m0_we_i = w; m0_sel_i = 4'hF; m0_adr_i = a; m0_dat_i = d;
   endtask

   task automatic set_m1(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d);
      m1_cyc_i = c; m1_stb_i = c; m1_we_i = w; m1_sel_i = 4'hF; m1_adr_i = a; m1_dat_i = d;
   endtask

   // Absolute time bound so a broken design can never hang the run.
   initial begin
      #200000;
      $display("FAIL time_limit: observed no finish expected finish before 200000");
      $fatal(1, "time limit");
   end

   initial begin
      wb_rstn_i = 1'b0;
      s_ack_i = 1'b0; s_dat_i = 32'h0;
      set_m0(1'b0, 1'b0, 32'h0, 32'h0);
      set_m1(1'b0, 1'b0, 32'h0, 32'h0);

      // ---- reset state ----
      next_cycle(); next_cycle(); mid();
      check2("rst_grant", grant_o, 2'b00);
      check1("rst_cyc", s_cyc_o, 1'b0);
      check1("rst_stb", s_stb_o, 1'b0);
      check1("rst_ack0", m0_ack_o, 1'b0);
      check1("rst_ack1", m1_ack_o, 1'b0);
      check1("rst_timeout", timeout_o, 1'b0);
      check32("rst_dat0", m0_dat_o, 32'h0);
      next_cycle(); wb_rstn_i = 1'b1;

      // ---- simultaneous first request: m0 wins, m1 follows with no gap ----
      next_cycle();
      set_m0(1'b1, 1'b0, 32'h20, 32'h0); set_m1(1'b1, 1'b0, 32'h30, 32'h0);
      exp_q.push_back(32'hAAAA_0000);
      mid(); check2("tie_req_grant", grant_o, 2'b00);
      next_cycle(); mid();
      check2("tie_grant_m0", grant_o, 2'b01);
      check32("tie_adr_m0", s_adr_o, 32'h20);
      next_cycle(); s_ack_i = 1'b1; s_dat_i = 32'hAAAA_0000; set_m0(1'b0, 1'b0, 32'h20, 32'h0);
      mid();
      expect_rd("tie_m0", m0_ack_o, m0_dat_o);
      check1("tie_no_ack_m1", m1_ack_o, 1'b0);
      check32("tie_no_dat_m1", m1_dat_o, 32'h0);
      next_cycle(); s_ack_i = 1'b0; exp_q.push_back(32'hBBBB_1111);
      mid();
      check2("tie_handover", grant_o, 2'b10);
      check32("tie_adr_m1", s_adr_o, 32'h30);
      check1("tie_stb_m1", s_stb_o, 1'b1);
      next_cycle(); s_ack_i = 1'b1; s_dat_i = 32'hBBBB_1111; set_m1(1'b0, 1'b0, 32'h30, 32'h0);
      mid(); expect_rd("tie_m1", m1_ack_o, m1_dat_o);
      next_cycle(); s_ack_i = 1'b0;

      // ---- single master write then read-back ----
      next_cycle(); set_m0(1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678);
      mid(); check1("wr_stb_req_cycle", s_stb_o, 1'b0);
      next_cycle(); mid();
      check1("wr_stb", s_stb_o, 1'b1);
      check1("wr_we", s_we_o, 1'b1);
      check32("wr_adr", s_adr_o, 32'h0000_0010);
      check32("wr_dat", s_dat_o, 32'h1234_5678);
      check2("wr_grant", grant_o, 2'b01);
      check1("wr_no_ack_yet", m0_ack_o, 1'b0);
      next_cycle(); s_ack_i = 1'b1; set_m0(1'b0, 1'b0, 32'h0000_0010, 32'h0);
      mid(); check1("wr_ack", m0_ack_o, 1'b1);
      next_cycle(); s_ack_i = 1'b0; set_m0(1'b1, 1'b0, 32'h0000_0010, 32'h0);
      exp_q.push_back(32'h1234_5678);
      mid(); check2("rd_req_grant", grant_o, 2'b00);
      next_cycle(); mid();
      check1("rd_stb", s_stb_o, 1'b1);
      check1("rd_we", s_we_o, 1'b0);
      next_cycle(); s_ack_i = 1'b1; s_dat_i = 32'h1234_5678; set_m0(1'b0, 1'b0, 32'h0000_0010, 32'h0);
      mid(); expect_rd("rd_back", m0_ack_o, m0_dat_o);
      next_cycle(); s_ack_i = 1'b0;

      // ---- hold limit: m0 gets 4 acks, m1 one, then m0 the remaining 4 ----
      next_cycle(); set_m0(1'b1, 1'b0, 32'h100, 32'h0);
      mid(); check2("hold_idle", grant_o, 2'b00);
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         set_m0(1'b1, 1'b0, 32'h100 + 32'(4 * i), 32'h0);
         set_m1(1'b1, 1'b0, 32'h200, 32'h0);
         s_ack_i = 1'b1; s_dat_i = 32'h1000 + 32'(i); exp_q.push_back(32'h1000 + 32'(i));
         mid();
         check2("hold_m0_grant", grant_o, 2'b01);
         expect_rd("hold_m0", m0_ack_o, m0_dat_o);
         check1("hold_m1_idle", m1_ack_o, 1'b0);
      end
      next_cycle();
      set_m0(1'b1, 1'b0, 32'h110, 32'h0); set_m1(1'b0, 1'b0, 32'h200, 32'h0);
      s_dat_i = 32'h2000_0001; exp_q.push_back(32'h2000_0001);
      mid();
      check2("hold_m1_grant", grant_o, 2'b10);
      check32("hold_m1_adr", s_adr_o, 32'h200);
      expect_rd("hold_m1", m1_ack_o, m1_dat_o);
      check1("hold_m0_waits", m0_ack_o, 1'b0);
      for (int i = 4; i < 8; i++) begin
         next_cycle();
         set_m0((i != 7) ? 1'b1 : 1'b0, 1'b0, 32'h100 + 32'(4 * i), 32'h0);
         if (i == 7) m0_stb_i = 1'b0;
         s_dat_i = 32'h1000 + 32'(i); exp_q.push_back(32'h1000 + 32'(i));
         mid();
         check2("hold_m0_resume", grant_o, 2'b01);
         expect_rd("hold_m0b", m0_ack_o, m0_dat_o);
      end
      next_cycle(); s_ack_i = 1'b0;

      // ---- watchdog: slave never acks ----
      next_cycle(); set_m0(1'b1, 1'b0, 32'h300, 32'h0); exp_q.push_back(32'hDEAD_BEEF);
      mid();
      for (int j = 1; j < 16; j++) begin
         next_cycle(); mid();
         check1("wd_stall_no_ack", m0_ack_o, 1'b0);
         check1("wd_stall_stb", s_stb_o, 1'b1);
      end
      next_cycle(); mid();
      expect_rd("wd_fire", m0_ack_o, m0_dat_o);
      check1("wd_fire_stb", s_stb_o, 1'b0);
      check1("wd_fire_cyc", s_cyc_o, 1'b0);
      check1("wd_fire_m1", m1_ack_o, 1'b0);
      next_cycle(); set_m0(1'b0, 1'b0, 32'h300, 32'h0); s_ack_i = 1'b1; s_dat_i = 32'h0000_5A5A;
      mid();
      check1("wd_late_ack0", m0_ack_o, 1'b0);
      check1("wd_late_ack1", m1_ack_o, 1'b0);
      check32("wd_late_dat0", m0_dat_o, 32'h0);
      check1("wd_sticky", timeout_o, 1'b1);
      check2("wd_flush_grant", grant_o, 2'b00);
      next_cycle(); s_ack_i = 1'b0; mid();
      check1("wd_flush_cyc", s_cyc_o, 1'b0);
      next_cycle(); set_m0(1'b1, 1'b0, 32'h340, 32'h0); exp_q.push_back(32'h3400_0000);
      mid(); check2("wd_flush_hold", grant_o, 2'b00);
      next_cycle(); mid(); check2("wd_flush_exit_idle", grant_o, 2'b00);
      next_cycle(); mid(); check2("wd_regrant", grant_o, 2'b01);
      next_cycle(); s_ack_i = 1'b1; s_dat_i = 32'h3400_0000; set_m0(1'b0, 1'b0, 32'h340, 32'h0);
      mid(); expect_rd("wd_after", m0_ack_o, m0_dat_o);
      check1("wd_still_sticky", timeout_o, 1'b1);
      next_cycle(); s_ack_i = 1'b0;

      // ---- reset in the cycle before the slave ack ----
      next_cycle(); set_m1(1'b1, 1'b0, 32'h400, 32'h0);
      mid();
      next_cycle(); wb_rstn_i = 1'b0;
      mid(); check2("rst_mid_pre_grant", grant_o, 2'b10);
      next_cycle(); wb_rstn_i = 1'b1; s_ack_i = 1'b1; s_dat_i = 32'h0000_5555;
      mid();
      check2("rst_mid_grant", grant_o, 2'b00);
      check1("rst_mid_cyc", s_cyc_o, 1'b0);
      check1("rst_mid_stb", s_stb_o, 1'b0);
      check32("rst_mid_adr", s_adr_o, 32'h0);
      check1("rst_mid_ack1", m1_ack_o, 1'b0);
      check32("rst_mid_dat1", m1_dat_o, 32'h0);
      check1("rst_mid_timeout", timeout_o, 1'b0);
      next_cycle(); s_ack_i = 1'b0; exp_q.push_back(32'h4444_0000);
      mid();
      check2("rst_mid_regrant", grant_o, 2'b10);
      check1("rst_mid_restb", s_stb_o, 1'b1);
      next_cycle(); s_ack_i = 1'b1; s_dat_i = 32'h4444_0000; set_m1(1'b0, 1'b0, 32'h400, 32'h0);
      mid(); expect_rd("rst_mid_m1", m1_ack_o, m1_dat_o);
      next_cycle(); s_ack_i = 1'b0;

      // ---- master abort by m1, then m0 granted one cycle after its request ----
      next_cycle(); set_m1(1'b1, 1'b1, 32'h500, 32'h0000_0777);
      mid();
      next_cycle(); mid();
      check2("abort_grant", grant_o, 2'b10);
      check1("abort_we", s_we_o, 1'b1);
      next_cycle(); set_m1(1'b0, 1'b0, 32'h500, 32'h0);
      mid();
      check1("abort_cyc", s_cyc_o, 1'b0);
      check1("abort_no_ack", m1_ack_o, 1'b0);
      next_cycle(); set_m0(1'b1, 1'b0, 32'h600, 32'h0); exp_q.push_back(32'h6666_0000);
      mid(); check2("abort_idle", grant_o, 2'b00);
      next_cycle(); mid();
      check2("abort_m0_grant", grant_o, 2'b01);
      check1("abort_m0_stb", s_stb_o, 1'b1);
      check32("abort_m0_adr", s_adr_o, 32'h600);
      next_cycle(); s_ack_i = 1'b1; s_dat_i = 32'h6666_0000; set_m0(1'b0, 1'b0, 32'h600, 32'h0);
      mid(); expect_rd("abort_m0", m0_ack_o, m0_dat_o);
      next_cycle(); s_ack_i = 1'b0;
      next_cycle(); mid();
      check2("end_idle", grant_o, 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
